// File: rtl/cpu_trace_pkg.sv
// Shared encodings and widths for the CPU trace extractor.
package cpu_trace_pkg;

  localparam int unsigned TIME_W = 16;
  localparam int unsigned WORD_W = 32;

  // cpu_checker format_type verdicts
  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_GRF  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StTime,
    StPc,
    StWaitTgt,
    StGrf,
    StAddr,
    StWaitData,
    StData
  } state_e;

endpackage

// File: rtl/trace_char_decode.sv
// Combinational ASCII classifier: decimal digit, lowercase hex digit, nibble value.
module trace_char_decode (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_lc;

  // Classify the character and derive its 4-bit value
  always_comb begin
    is_dec = (char >= "0") && (char <= "9");
    is_lc  = (char >= "a") && (char <= "f");
    is_hex = is_dec || is_lc;
    nibble = 4'h0;
    if (is_dec) begin
      nibble = char[3:0];
    end else if (is_lc) begin
      // 'a' = 0x61, so low nibble 1..6 maps to 10..15
      nibble = char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_trace_extractor.sv
// Parses "^time@pc: $reg <= data#" / "^time@pc: *addr <= data#" trace records and
// presents the captured fields when cpu_checker flags the record as well-formed.
// Optional build macro CPU_TRACE_EXTRACTOR_COUNT_EN adds a saturating rec_count output.
module cpu_trace_extractor
  import cpu_trace_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [1:0]        format_type,
  output logic              rec_valid,
  output logic [1:0]        rec_type,
  output logic [TIME_W-1:0] rec_time,
  output logic [WORD_W-1:0] rec_pc,
  output logic [WORD_W-1:0] rec_target,
  output logic [WORD_W-1:0] rec_data
`ifdef CPU_TRACE_EXTRACTOR_COUNT_EN
  ,
  output logic [15:0]       rec_count
`endif
);

  logic       is_dec;
  logic       is_hex;
  logic [3:0] nibble;

  trace_char_decode u_decode (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  state_e state_q, state_d;

  // Working fields, built up while a record streams in
  logic [TIME_W-1:0] tim_q, tim_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] tgt_q, tgt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              capture;

  // Hold fields: last complete record, waiting for cpu_checker's verdict
  logic [TIME_W-1:0] hold_tim_q;
  logic [WORD_W-1:0] hold_pc_q, hold_tgt_q, hold_data_q;

  // Presented record
  logic              rec_valid_q;
  logic [1:0]        rec_type_q;
  logic [TIME_W-1:0] rec_tim_q;
  logic [WORD_W-1:0] rec_pc_q, rec_tgt_q, rec_data_q;

  // Next-state and field accumulation for the record parser
  always_comb begin
    state_d = state_q;
    tim_d   = tim_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    data_d  = data_q;
    capture = 1'b0;
    if (char == "^") begin
      state_d = StTime;
      tim_d   = '0;
      pc_d    = '0;
      tgt_d   = '0;
      data_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StTime: begin
          if (is_dec)           tim_d   = tim_q * TIME_W'(10) + TIME_W'(nibble);
          else if (char == "@") state_d = StPc;
          else                  state_d = StIdle;
        end
        StPc: begin
          if (is_hex)           pc_d    = {pc_q[WORD_W-5:0], nibble};
          else if (char == ":") state_d = StWaitTgt;
          else                  state_d = StIdle;
        end
        StWaitTgt: begin
          if (char == "$")      state_d = StGrf;
          else if (char == "*") state_d = StAddr;
          else if (char != " ") state_d = StIdle;
        end
        StGrf: begin
          if (is_dec)                         tgt_d   = tgt_q * WORD_W'(10) + WORD_W'(nibble);
          else if (char == " " || char == "<") state_d = StWaitData;
          else                                state_d = StIdle;
        end
        StAddr: begin
          if (is_hex)                         tgt_d   = {tgt_q[WORD_W-5:0], nibble};
          else if (char == " " || char == "<") state_d = StWaitData;
          else                                state_d = StIdle;
        end
        StWaitData: begin
          if (is_hex) begin
            data_d  = WORD_W'(nibble);
            state_d = StData;
          end else if (char != " " && char != "<" && char != "=") begin
            state_d = StIdle;
          end
        end
        StData: begin
          if (is_hex) begin
            data_d = {data_q[WORD_W-5:0], nibble};
          end else begin
            state_d = StIdle;
            capture = (char == "#");
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Parser state and working-field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tim_q   <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tim_q   <= tim_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
    end
  end

  // Latch a finished record when its terminating '#' arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_tim_q  <= '0;
      hold_pc_q   <= '0;
      hold_tgt_q  <= '0;
      hold_data_q <= '0;
    end else if (capture) begin
      hold_tim_q  <= tim_q;
      hold_pc_q   <= pc_q;
      hold_tgt_q  <= tgt_q;
      hold_data_q <= data_q;
    end
  end

  // Present the held record for one cycle whenever cpu_checker accepts it
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_valid_q <= 1'b0;
      rec_type_q  <= FMT_NONE;
      rec_tim_q   <= '0;
      rec_pc_q    <= '0;
      rec_tgt_q   <= '0;
      rec_data_q  <= '0;
    end else if (format_type != FMT_NONE) begin
      rec_valid_q <= 1'b1;
      rec_type_q  <= format_type;
      rec_tim_q   <= hold_tim_q;
      rec_pc_q    <= hold_pc_q;
      rec_tgt_q   <= hold_tgt_q;
      rec_data_q  <= hold_data_q;
    end else begin
      rec_valid_q <= 1'b0;
      rec_type_q  <= FMT_NONE;
    end
  end

  assign rec_valid  = rec_valid_q;
  assign rec_type   = rec_type_q;
  assign rec_time   = rec_tim_q;
  assign rec_pc     = rec_pc_q;
  assign rec_target = rec_tgt_q;
  assign rec_data   = rec_data_q;

`ifdef CPU_TRACE_EXTRACTOR_COUNT_EN
  logic [15:0] count_q;

  // Saturating count of presented records
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (rec_valid_q && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign rec_count = count_q;
`endif

endmodule

// File: tb/tb_cpu_trace_extractor.sv
// Scoreboard bench for cpu_trace_extractor: drivers push expected records,
// a negedge monitor pops and compares whenever rec_valid is seen.
module tb_cpu_trace_extractor;

  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] tim;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ch = 8'h00;
  logic [1:0]  fmt = 2'd0;
  logic        rec_valid;
  logic [1:0]  rec_type;
  logic [15:0] rec_time;
  logic [31:0] rec_pc, rec_target, rec_data;
`ifdef CPU_TRACE_EXTRACTOR_COUNT_EN
  logic [15:0] rec_count;
`endif

  cpu_trace_extractor dut (
    .clk         (clk),
    .reset       (reset),
    .char        (ch),
    .format_type (fmt),
    .rec_valid   (rec_valid),
    .rec_type    (rec_type),
    .rec_time    (rec_time),
    .rec_pc      (rec_pc),
    .rec_target  (rec_target),
    .rec_data    (rec_data)
`ifdef CPU_TRACE_EXTRACTOR_COUNT_EN
    ,
    .rec_count   (rec_count)
`endif
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  rec_t mon_e, mon_a;

  localparam rec_t ZERO = '0;
  localparam rec_t E021 = '{typ: 2'd1, tim: 16'd0, pc: 32'h0, tgt: 32'h0, data: 32'h0};
  localparam rec_t E029 = '{typ: 2'd1, tim: 16'd1024, pc: 32'h00003ffc, tgt: 32'd2,
                            data: 32'h89abcdef};
  localparam rec_t E030 = '{typ: 2'd2, tim: 16'd7, pc: 32'h00400010, tgt: 32'h0000ff0c,
                            data: 32'h0000000a};
  localparam rec_t EA   = '{typ: 2'd1, tim: 16'd5, pc: 32'h00000100, tgt: 32'd31,
                            data: 32'hdeadbeef};
  localparam rec_t EB   = '{typ: 2'd2, tim: 16'd65535, pc: 32'hffffffff, tgt: 32'h00001000,
                            data: 32'h12345678};
  // 70000 wraps to 4464; 9 pc digits keep the low 8
  localparam rec_t EC   = '{typ: 2'd1, tim: 16'd4464, pc: 32'h23456789, tgt: 32'd7,
                            data: 32'h0};
  localparam rec_t EC2  = '{typ: 2'd2, tim: 16'd4464, pc: 32'h23456789, tgt: 32'd7,
                            data: 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(rec_valid), 32'd0);
    chk({tag, "_type"}, 32'(rec_type), 32'd0);
    chk({tag, "_time"}, 32'(rec_time), 32'd0);
    chk({tag, "_pc"}, rec_pc, 32'd0);
    chk({tag, "_target"}, rec_target, 32'd0);
    chk({tag, "_data"}, rec_data, 32'd0);
  endtask

  // Stream a string; format_type f0 rides along with the first character
  task automatic send(input string s, input logic [1:0] f0, input rec_t e0);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ch  = s[i];
      fmt = (i == 0) ? f0 : 2'd0;
      if (i == 0 && f0 != 2'd0) exp_q.push_back(e0);
    end
  endtask

  task automatic present(input logic [1:0] f, input rec_t e);
    @(negedge clk);
    ch  = 8'h00;
    fmt = f;
    if (f != 2'd0) exp_q.push_back(e);
    @(negedge clk);
    fmt = 2'd0;
  endtask

  // Monitor: every presented record must match the oldest expected one
  always @(negedge clk) begin
    if (rec_valid === 1'b1) begin
      n_checks++;
      mon_a = {rec_type, rec_time, rec_pc, rec_target, rec_data};
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_record: got type=%0d time=%0d pc=%h tgt=%h data=%h, expected none",
                 rec_type, rec_time, rec_pc, rec_target, rec_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a === mon_e) n_pass++;
        else $display({"FAIL record: got type=%0d time=%0d pc=%h tgt=%h data=%h, ",
                       "expected type=%0d time=%0d pc=%h tgt=%h data=%h"},
                      mon_a.typ, mon_a.tim, mon_a.pc, mon_a.tgt, mon_a.data,
                      mon_e.typ, mon_e.tim, mon_e.pc, mon_e.tgt, mon_e.data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Verdict with nothing captured yet presents zeros
    present(2'd1, E021);

    // Well-formed record but checker never accepts it
    send("^1024@00003ffc: $2 <= 89abcdef#", 2'd0, ZERO);
    repeat (3) @(negedge clk);
    check_zero("no_verdict");

    send("^1024@00003ffc: $2 <= 89abcdef#", 2'd0, ZERO);
    present(2'd1, E029);

    send("^7@00400010: *0000ff0c <= 0000000a#", 2'd0, ZERO);
    present(2'd2, E030);

    // Back-to-back: second '^' shares the edge with the first verdict
    send("^5@00000100: $31 <= deadbeef#", 2'd0, ZERO);
    send("^65535@ffffffff: *00001000 <= 12345678#", 2'd1, EA);
    present(2'd2, EB);

    send("^70000@123456789: $7 <= 0#", 2'd0, ZERO);
    present(2'd1, EC);

    // Uppercase hex aborts; the trailing '#' must not overwrite the hold record
    send("^3@0A: $1 <= 5#", 2'd0, ZERO);
    present(2'd2, EC2);

    // Reset mid-record, with a verdict on the same edge
    send("^12@0000", 2'd0, ZERO);
    @(negedge clk);
    reset = 1'b1;
    fmt   = 2'd1;
    ch    = "9";
    @(negedge clk);
    reset = 1'b0;
    fmt   = 2'd0;
    check_zero("mid_reset");

    send("^7@00400010: *0000ff0c <= 0000000a#", 2'd0, ZERO);
    present(2'd2, E030);

`ifdef CPU_TRACE_EXTRACTOR_COUNT_EN
    present(2'd2, E030);
    present(2'd2, E030);
    @(negedge clk);
    chk("count_three", 32'(rec_count), 32'd3);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    present(2'd2, E030);
    @(negedge clk);
    chk("count_saturate", 32'(rec_count), 32'h0000FFFF);
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_extractor.md
CPU_TRACE_EXTRACTOR -- requirements
Module: cpu_trace_extractor

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; it SHALL be a downstream stage fed by the same character stream as cpu_checker and by cpu_checker's format_type output.
REQ-002 clk  input  1  rising-edge clock shared with cpu_checker.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 char  input  8  ASCII trace character, sampled every rising edge.
REQ-005 format_type  input  2  cpu_checker verdict: 0 = none, 1 = register record, 2 = memory record.
REQ-006 rec_valid  output  1  one-cycle pulse: a checked record is presented.
REQ-007 rec_type  output  2  copy of format_type for the presented record.
REQ-008 rec_time  output  16  decimal time field.
REQ-009 rec_pc  output  32  hex PC field.
REQ-010 rec_target  output  32  register number (decimal, zero-extended) or memory address (hex).
REQ-011 rec_data  output  32  hex data field.

Function
REQ-012 The FSM SHALL have states IDLE, TIME, PC, WAIT_TGT, GRF, ADDR, WAIT_DATA and DATA; '^' in any state SHALL clear the working fields and enter TIME.
REQ-013 Transitions: TIME on '@' -> PC; PC on ':' -> WAIT_TGT; WAIT_TGT ignores ' ', goes to GRF on '$' and to ADDR on '*'; GRF/ADDR on ' ' or '<' -> WAIT_DATA; WAIT_DATA ignores ' ', '<', '=' and loads the first hex digit while entering DATA; DATA on '#' -> IDLE.
REQ-014 Any other unexpected character SHALL send the FSM to IDLE without touching the hold registers.
REQ-015 Decimal fields SHALL accumulate as acc*10 + digit, truncated to 16 bits; hex fields SHALL accumulate as (acc<<4) | nibble, keeping the low 32 bits.
REQ-016 Hex digits SHALL be '0'-'9' and 'a'-'f' (lowercase only); decimal digits SHALL be '0'-'9'.
REQ-017 When '#' is sampled in DATA, the working fields SHALL be copied into the hold registers on that edge.
REQ-018 At each edge where format_type is non-zero, the block SHALL drive rec_valid = 1 and rec_type = format_type for the next cycle, with rec_time/pc/target/data taken from the hold registers. This gives latency 1 cycle after cpu_checker asserts format_type, which is 2 edges after '#'.
REQ-019 rec_* data outputs SHALL hold their values until the next presented record; rec_valid and rec_type SHALL return to 0 one cycle later.
REQ-020 A '^' sampled on the same edge as non-zero format_type SHALL restart parsing and SHALL NOT corrupt the record being presented.
REQ-021 Non-zero format_type with no '#' ever captured since reset SHALL present all-zero fields.

Reset
REQ-022 Reset SHALL force state IDLE and clear working fields, hold registers and all outputs to 0.
REQ-023 Reset SHALL take priority over char and format_type on the same edge.
REQ-024 Reset in the middle of a record SHALL discard that record entirely.

Configuration
REQ-025 With CPU_TRACE_EXTRACTOR_COUNT_EN defined, the block SHALL add output rec_count (16 bits, reset 0). rec_count SHALL increment on every rec_valid pulse and saturate at 0xFFFF.
REQ-026 Without CPU_TRACE_EXTRACTOR_COUNT_EN, the rec_count port and its counter SHALL NOT exist.

Structure
REQ-027 Package cpu_trace_pkg SHALL hold the format_type encodings (NONE = 0, GRF = 1, MEM = 2), the FSM state enum, and the width constants TIME_W = 16 and WORD_W = 32.
REQ-028 Sub-module trace_char_decode SHALL be combinational and map char to {is_dec, is_hex, nibble[3:0]}.

Verification
REQ-029 "^1024@00003ffc: $2 <= 89abcdef#" with format_type = 1 driven on the edge after '#' -> rec_valid for 1 cycle; rec_type = 1, rec_time = 1024, rec_pc = 0x00003ffc, rec_target = 2, rec_data = 0x89abcdef.
REQ-030 "^7@00400010: *0000ff0c <= 0000000a#" with format_type = 2 -> rec_type = 2, rec_time = 7, rec_pc = 0x00400010, rec_target = 0x0000ff0c, rec_data = 0x0000000a.
REQ-031 Record from REQ-029 with format_type held at 0 -> rec_valid stays 0 and all rec_* stay 0.
REQ-032 Back-to-back records, with the second '^' sampled on the same edge as format_type = 1 for the first -> both records are presented with correct, uncorrupted fields.
REQ-033 Reset asserted after "^12@0000" and released, then the record from REQ-030 -> only the REQ-030 record appears, with rec_time = 7.
REQ-034 With CPU_TRACE_EXTRACTOR_COUNT_EN defined and three valid records -> rec_count = 3; forcing the counter to 0xFFFF then one more record -> rec_count stays 0xFFFF.
